// File: rtl/ram_1w_1rs_fifo_ctrl.sv
// ram_1w_1rs_fifo_ctrl: FIFO controller in front of an external RAM with one
// write port and one read port (1-cycle read latency). A 2-entry output queue
// absorbs the RAM read latency so a word can leave every cycle.
// Optional feature: define RAM_FIFO_CTRL_BYPASS_EN to let a pushed word skip
// the RAM when nothing is stored or in flight and the queue has room.
module ram_1w_1rs_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_payload,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_payload,
  output logic [ADDR_WIDTH+1:0] occupancy,
  output logic                  ram_wr_en,
  output logic [MASK_WIDTH-1:0] ram_wr_mask,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W = ADDR_WIDTH + 2;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  rd_inflight_q;
  logic [DATA_WIDTH-1:0] q_mem_q [2];
  logic                  q_head_q, q_head_d;
  logic [1:0]            q_cnt_q, q_cnt_d;

  logic [PTR_W-1:0]      ram_count;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  bypass;
  logic [2:0]            q_use;
  logic                  q_wr;
  logic                  q_wr_idx;
  logic [DATA_WIDTH-1:0] q_wr_data;

  // Handshakes, RAM port drive and queue write selection
  always_comb begin
    ram_count   = wr_ptr_q - rd_ptr_q;
    push_ready  = (ram_count < DEPTH);
    pop_valid   = (q_cnt_q != 2'd0);
    pop_payload = q_mem_q[q_head_q];
    pop_fire    = pop_valid & pop_ready;
    push_fire   = push_valid & push_ready & resetn;
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    bypass = (ram_count == '0) && !rd_inflight_q &&
             ((3'(q_cnt_q) - 3'(pop_fire)) < 3'd2);
`else
    bypass = 1'b0;
`endif
    // Queue slots already owed: held words plus the returning read, minus
    // the word leaving now. A new read is issued only if its data will fit.
    q_use       = 3'(q_cnt_q) + 3'(rd_inflight_q) - 3'(pop_fire);
    ram_rd_en   = (ram_count != '0) && (q_use < 3'd2);
    ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    ram_wr_en   = push_fire & ~bypass;
    ram_wr_mask = '1;
    ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    ram_wr_data = push_payload;
    // Read return and bypass never coincide (bypass needs no read in flight).
    // With a full queue and a same-cycle pop, head^cnt[0] selects the slot
    // being vacated, which becomes the new tail.
    q_wr        = rd_inflight_q | (push_fire & bypass);
    q_wr_data   = rd_inflight_q ? ram_rd_data : push_payload;
    q_wr_idx    = q_head_q ^ q_cnt_q[0];
    occupancy   = OCC_W'(ram_count) + OCC_W'(rd_inflight_q) + OCC_W'(q_cnt_q);
  end

  // Next-state for pointers and queue bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(ram_wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(ram_rd_en);
    q_head_d = q_head_q ^ pop_fire;
    q_cnt_d  = q_cnt_q + 2'(q_wr) - 2'(pop_fire);
  end

  // Control state register; reset drops all stored and in-flight words
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_inflight_q <= 1'b0;
      q_head_q      <= 1'b0;
      q_cnt_q       <= 2'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_inflight_q <= ram_rd_en;
      q_head_q      <= q_head_d;
      q_cnt_q       <= q_cnt_d;
    end
  end

  // Output queue storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_mem_q[0] <= '0;
      q_mem_q[1] <= '0;
    end else if (q_wr) begin
      q_mem_q[q_wr_idx] <= q_wr_data;
    end
  end

endmodule

// File: tb/tb_ram_1w_1rs_fifo_ctrl.sv
// Testbench for ram_1w_1rs_fifo_ctrl: behavioural RAM, queue-based scoreboard
// (words held = pushed minus popped), directed and randomized scenarios.
`timescale 1ns/1ps
module tb_ram_1w_1rs_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int DEPTH = 16;
`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam int LAT    = 1;
  localparam bit BYPASS = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_payload;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_payload;
  logic [AW+1:0] occupancy;
  logic          ram_wr_en;
  logic [MW-1:0] ram_wr_mask;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];

  ram_1w_1rs_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MASK_WIDTH(MW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready), .push_payload(push_payload),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_payload(pop_payload),
    .occupancy(occupancy),
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 1-cycle read latency, garbage on the bus when not read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    else           ram_rd_data <= $urandom;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    push_valid   = 1'b0;
    pop_ready    = 1'b0;
    push_payload = '0;
    resetn       = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; push_valid = 1'b1; push_payload = 32'h1234_5678; pop_ready = 1'b1;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
    checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
    checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ram_rd_en); end
    @(negedge clk); #1;
    checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL reset_hold_occupancy: got %0d expected 0", occupancy); end
    push_valid = 1'b0; pop_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    pop_ready = 1'b1;
    @(negedge clk);
    push_valid = 1'b1; push_payload = 32'hDEAD_BEEF;
    #1;
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL single_push_ready: got %b expected 1", push_ready); end
    checks++; if (ram_wr_en !== !BYPASS) begin errors++; $display("FAIL single_wr_en: got %b expected %b", ram_wr_en, !BYPASS); end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      push_valid = 1'b0;
      #1;
      checks++; if (ram_rd_en !== (k == 1 && !BYPASS)) begin errors++; $display("FAIL single_rd_en_t%0d: got %b expected %b", k, ram_rd_en, (k == 1 && !BYPASS)); end
      checks++; if (pop_valid !== (k == LAT)) begin errors++; $display("FAIL single_pop_valid_t%0d: got %b expected %b", k, pop_valid, (k == LAT)); end
      checks++; if (occupancy !== 6'd1) begin errors++; $display("FAIL single_occupancy_t%0d: got %0d expected 1", k, occupancy); end
      if (k == LAT) begin
        checks++; if (pop_payload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_payload: got %h expected deadbeef", pop_payload); end
      end
    end
    @(negedge clk); #1;
    checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL single_occ_after: got %0d expected 0", occupancy); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid_after: got %b expected 0", pop_valid); end
  endtask

  task automatic test_fill();
    int fired = 0;
    int cyc = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      push_valid = 1'b1; push_payload = 32'hA000_0000 + fired;
      #1;
      checks++; if (ram_wr_en && !push_ready) begin errors++; $display("FAIL fill_wr_when_full: got wr_en=1 expected 0"); end
      if (push_ready) begin exp_q.push_back(push_payload); fired++; end
    end
    checks++; if (fired != 18) begin errors++; $display("FAIL fill_accepted: got %0d expected 18", fired); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready: got %b expected 0", push_ready); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL fill_stall_wr_en: got %b expected 0", ram_wr_en); end
    checks++; if (occupancy !== 6'd18) begin errors++; $display("FAIL fill_occupancy: got %0d expected 18", occupancy); end
    checks++; if (pop_valid !== 1'b1 || pop_payload !== 32'hA000_0000) begin errors++; $display("FAIL fill_head: got %b/%h expected 1/a0000000", pop_valid, pop_payload); end
    push_valid = 1'b0;
    while (exp_q.size() != 0 && cyc < 80) begin
      @(negedge clk);
      pop_ready = 1'b1;
      #1;
      cyc++;
      checks++; if (occupancy !== 6'(exp_q.size())) begin errors++; $display("FAIL fill_drain_occ: got %0d expected %0d", occupancy, exp_q.size()); end
      if (pop_valid) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checks++; if (pop_payload !== e) begin errors++; $display("FAIL fill_drain_data: got %h expected %h", pop_payload, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_drain_timeout: got %0d left expected 0", exp_q.size()); end
    @(negedge clk); #1;
    checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL fill_final_occ: got %0d expected 0", occupancy); end
    pop_ready = 1'b0;
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    int last_pop = -1;
    do_reset();
    for (int c = 0; c < 400 && got < 100; c++) begin
      @(negedge clk);
      push_valid = (sent < 100); push_payload = 32'h0000_0100 + sent; pop_ready = 1'b1;
      #1;
      checks++; if (occupancy !== 6'(exp_q.size())) begin errors++; $display("FAIL stream_occ: got %0d expected %0d", occupancy, exp_q.size()); end
      checks++; if (ram_wr_en && !push_ready) begin errors++; $display("FAIL stream_wr_when_full: got wr_en=1 expected 0"); end
      if (push_valid) begin
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL stream_push_ready: got %b expected 1", push_ready); end
      end
      if (pop_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL stream_spurious_pop: got %h expected none", pop_payload);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          checks++; if (pop_payload !== e) begin errors++; $display("FAIL stream_data: got %h expected %h", pop_payload, e); end
          if (got == 0) begin
            checks++; if (c != LAT) begin errors++; $display("FAIL stream_first_pop: got cycle %0d expected %0d", c, LAT); end
          end else begin
            checks++; if (c - last_pop != 1) begin errors++; $display("FAIL stream_gap: got %0d cycles expected 1", c - last_pop); end
          end
          last_pop = c;
          got++;
        end
      end
      if (push_valid && push_ready) begin exp_q.push_back(push_payload); sent++; end
    end
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", got); end
    push_valid = 1'b0; pop_ready = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int pv = 70;
    int pr = 70;
    do_reset();
    for (int c = 0; c < 30000 && got < 2000; c++) begin
      if (c % 300 == 0) begin pv = $urandom_range(95, 20); pr = $urandom_range(95, 20); end
      @(negedge clk);
      push_valid   = (sent < 2000) && ($urandom_range(99) < pv);
      push_payload = $urandom;
      pop_ready    = ($urandom_range(99) < pr);
      #1;
      checks++; if (occupancy !== 6'(exp_q.size())) begin errors++; $display("FAIL rand_occ: got %0d expected %0d", occupancy, exp_q.size()); end
      checks++; if (exp_q.size() < DEPTH && push_ready !== 1'b1) begin errors++; $display("FAIL rand_push_ready: got %b expected 1 (held %0d)", push_ready, exp_q.size()); end
      checks++; if (ram_wr_en && !(push_valid && push_ready)) begin errors++; $display("FAIL rand_wr_without_push: got wr_en=1 expected 0"); end
      checks++; if (push_valid && push_ready && !BYPASS && ram_wr_en !== 1'b1) begin errors++; $display("FAIL rand_push_no_wr: got wr_en=%b expected 1", ram_wr_en); end
      if (ram_wr_en) begin
        checks++; if (ram_wr_addr !== 4'(wr_cnt % DEPTH) || ram_wr_mask !== 4'hF) begin errors++; $display("FAIL rand_wr_addr: got %0d/%h expected %0d/f", ram_wr_addr, ram_wr_mask, wr_cnt % DEPTH); end
        wr_cnt++;
      end
      if (ram_rd_en) begin
        checks++; if (ram_rd_addr !== 4'(rd_cnt % DEPTH)) begin errors++; $display("FAIL rand_rd_addr: got %0d expected %0d", ram_rd_addr, rd_cnt % DEPTH); end
        checks++; if (ram_wr_en && ram_wr_addr == ram_rd_addr) begin errors++; $display("FAIL rand_addr_clash: got wr=rd=%0d expected distinct", ram_rd_addr); end
        rd_cnt++;
      end
      if (pop_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious_pop: got %h expected none", pop_payload);
        end else if (pop_ready) begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          checks++; if (pop_payload !== e) begin errors++; $display("FAIL rand_data: got %h expected %h (word %0d)", pop_payload, e, got); end
          got++;
        end
      end
      if (push_valid && push_ready) begin exp_q.push_back(push_payload); sent++; end
    end
    checks++; if (got != 2000 || exp_q.size() != 0) begin errors++; $display("FAIL rand_complete: got %0d popped %0d left expected 2000/0", got, exp_q.size()); end
    checks++; if (wr_cnt < 2 * (DEPTH * 2) && !BYPASS) begin errors++; $display("FAIL rand_wrap: got %0d writes expected >= %0d", wr_cnt, 4 * DEPTH); end
    push_valid = 1'b0; pop_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int fired = 0;
    do_reset();
    for (int c = 0; c < 30 && fired < 7; c++) begin
      @(negedge clk);
      push_valid = 1'b1; push_payload = 32'hC000_0000 + fired;
      #1;
      if (push_ready) fired++;
    end
    @(negedge clk); push_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (occupancy !== 6'd7) begin errors++; $display("FAIL midop_occ_before: got %0d expected 7", occupancy); end
    @(negedge clk);
    pop_ready = 1'b1;
    #1;
    checks++; if (ram_rd_en !== 1'b1 || pop_valid !== 1'b1) begin errors++; $display("FAIL midop_read_issue: got rd_en=%b pop_valid=%b expected 1/1", ram_rd_en, pop_valid); end
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL midop_pop_valid: got %b expected 0", pop_valid); end
    checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL midop_occ: got %0d expected 0", occupancy); end
    checks++; if (push_ready !== 1'b1 || ram_rd_en !== 1'b0) begin errors++; $display("FAIL midop_ports: got ready=%b rd_en=%b expected 1/0", push_ready, ram_rd_en); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (pop_valid !== 1'b0 || occupancy !== 6'd0) begin errors++; $display("FAIL midop_stale_%0d: got valid=%b occ=%0d expected 0/0", k, pop_valid, occupancy); end
    end
    @(negedge clk);
    push_valid = 1'b1; push_payload = 32'h5A5A_A5A5;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      push_valid = 1'b0;
      #1;
    end
    checks++; if (pop_valid !== 1'b1 || pop_payload !== 32'h5A5A_A5A5) begin errors++; $display("FAIL midop_after: got %b/%h expected 1/5a5aa5a5", pop_valid, pop_payload); end
    pop_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_payload = '0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
